// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the instruction-memory program loader.
package loader_pkg;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: the first byte shifted in ends up in bits [31:24].
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    // word_next already includes the byte being shifted in this cycle.
    assign word_next = {word_q[23:0], byte_in};
    assign word_full = shift && (cnt_q == 2'(WORD_BYTES - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift) begin
            word_q <= word_next;
            cnt_q  <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed byte image into instruction memory, then releases the core.
// Optional trailer checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(MAX_WORDS) + 1;

    state_t            state, state_next;
    logic [15:0]       count_q;
    logic [15:0]       hdr_count;
    logic [IDX_W-1:0]  word_idx_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              core_rst_q;
    logic              xfer;
    logic              last_word;
    logic              pack_shift;
    logic              pack_clear;
    logic [31:0]       word_next;
    logic              word_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    // Readiness is decoded from the state alone; gating with rst keeps it low while reset is held.
    always_comb begin
        byte_ready = 1'b0;
        case (state)
            HDR_HI, HDR_LO, DATA: byte_ready = !rst;
`ifdef LOADER_CHECKSUM_EN
            CHK:                  byte_ready = !rst;
`endif
            default:              byte_ready = 1'b0;
        endcase
    end

    assign xfer       = byte_valid && byte_ready;
    assign hdr_count  = {count_q[15:8], byte_in};
    assign last_word  = (32'(word_idx_q) + 32'd1) == 32'(count_q);
    assign pack_shift = (state == DATA) && xfer;
    assign pack_clear = (state == HDR_LO) && xfer;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .shift     (pack_shift),
        .clear     (pack_clear),
        .byte_in   (byte_in),
        .word_next (word_next),
        .word_full (word_full)
    );

    // NOTE: state_next gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            HDR_HI: if (xfer) state_next = HDR_LO;
            HDR_LO: begin
                if (xfer) begin
                    if (hdr_count == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = DONE;
`endif
                    else if (32'(hdr_count) > MAX_WORDS)
                        state_next = ERR;
                    else
                        state_next = DATA;
                end
            end
            DATA:  if (word_full) state_next = WRITE;
            WRITE: begin
                if (last_word)
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                else
                    state_next = DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: if (xfer) state_next = (byte_in == csum_q) ? DONE : ERR;
`endif
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HDR_HI;
            count_q     <= '0;
            word_idx_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state <= state_next;
            if (state == HDR_HI && xfer) count_q[15:8] <= byte_in;
            if (state == HDR_LO && xfer) count_q[7:0]  <= byte_in;
            // Address and data are captured on the 4th byte so they are stable for the whole WRITE cycle.
            if (word_full) begin
                mem_addr_q  <= ADDR_W'({word_idx_q, 2'b00});
                mem_wdata_q <= word_next;
            end
            if (state == WRITE) word_idx_q <= word_idx_q + IDX_W'(1);
            if (state_next == DONE) core_rst_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (pack_shift) csum_q <= csum_q ^ byte_in;
`endif
        end
    end

    assign mem_we    = (state == WRITE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rst  = core_rst_q;
    assign done      = (state == DONE);
    assign err       = (state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed images plus randomized loads against a queue-based model.
module tb_prog_loader;

    localparam int MAX_WORDS = 256;
    localparam int ADDR_W    = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    logic [7:0] data_q[$];

    prog_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we === 1'b1) writes_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, {byte_ready, mem_we, core_rst, done, err}, 5'b00100);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs(tag);
        rst = 1'b0;
    endtask

    // mode 0: valid held high, 1: valid toggles every other cycle, 2: random gaps
    task automatic send_byte(input logic [7:0] b, input int mode);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((mode == 1 && i % 2 == 0) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                byte_valid = 1'b0;
                byte_in = 8'($urandom);
                continue;
            end
            byte_in = b;
            byte_valid = 1'b1;
            if (byte_ready) begin
                @(posedge clk);
                #1;
                byte_valid = 1'b0;
                byte_in = 8'($urandom);
                return;
            end
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic load_image(input int cnt, input int mode, input bit bad_trailer, input string tag);
        int base;
        logic [7:0] csum;
        logic [31:0] exp_w;
        bit exp_err;
        base = writes_seen;
        csum = 8'h00;
        exp_w = 32'h0;
        send_byte(8'(cnt >> 8), mode);
        send_byte(8'(cnt), mode);
        if (cnt > MAX_WORDS) begin
            @(negedge clk);
            check({tag, "_err_flags"}, {err, done, core_rst, byte_ready}, 4'b1010);
            repeat (20) begin
                @(negedge clk);
                byte_valid = 1'b1;
                byte_in = 8'($urandom);
            end
            @(negedge clk);
            byte_valid = 1'b0;
            check({tag, "_err_hold"}, {err, core_rst, byte_ready}, 3'b110);
            check({tag, "_err_writes"}, writes_seen - base, 0);
            return;
        end
        for (int w = 0; w < cnt; w++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(data_q[4*w+k], mode);
                csum ^= data_q[4*w+k];
                exp_w = (exp_w << 8) | 32'(data_q[4*w+k]);
            end
            @(negedge clk);
            check({tag, "_we"}, {mem_we, byte_ready}, 2'b10);
            check({tag, "_addr"}, mem_addr, 64'(4 * w));
            check({tag, "_wdata"}, mem_wdata, exp_w);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_trailer ? (csum ^ 8'h01) : csum, mode);
        exp_err = bad_trailer;
`else
        exp_err = 1'b0;
`endif
        @(negedge clk);
        check({tag, "_final"}, {done, err, core_rst, byte_ready, mem_we},
              exp_err ? 5'b01100 : 5'b10000);
        check({tag, "_nwrites"}, writes_seen - base, cnt);
        if (cnt > 0) check({tag, "_hold"}, mem_wdata, exp_w);
    endtask

    task automatic fill_random(input int n);
        data_q.delete();
        for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
    endtask

    initial begin
        int cnt;
        int base;
        bit bad;

        do_reset("rst0");
        @(negedge clk);
        check("rdy_after_rst", byte_ready, 1'b1);

        data_q = '{8'h01, 8'h20, 8'h00, 8'h05, 8'h02, 8'h10, 8'h00, 8'h07};
        load_image(2, 0, 1'b0, "two_word");

        do_reset("rst1");
        data_q.delete();
        load_image(0, 0, 1'b0, "zero");

        do_reset("rst2");
        load_image(257, 0, 1'b0, "too_big");

        do_reset("rst3");
        data_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load_image(1, 1, 1'b0, "toggle");

        // Reset one cycle after the 2nd byte of the second word; the first word stays written.
        do_reset("rst4");
        base = writes_seen;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        check("mid_rst_writes", writes_seen - base, 1);
        rst = 1'b0;
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_image(1, 0, 1'b0, "after_rst");

`ifdef LOADER_CHECKSUM_EN
        do_reset("rst5");
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_image(1, 0, 1'b0, "csum_good");
        do_reset("rst6");
        load_image(1, 0, 1'b1, "csum_bad");
`endif

        do_reset("rst7");
        fill_random(4 * MAX_WORDS);
        load_image(MAX_WORDS, 0, 1'b0, "max");

        for (int it = 0; it < 8; it++) begin
            do_reset("rst_rand");
            cnt = $urandom_range(1, 6);
            if (it == 5) cnt = MAX_WORDS + 1 + $urandom_range(0, 100);
            if (it == 6) cnt = 0;
            fill_random(4 * 6);
            bad = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            bad = 1'($urandom_range(0, 1));
`endif
            load_image(cnt, 2, bad, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
